noc_traffic_gen: RTL

Parametrised traffic generator that injects flits into one `noc` router input port, replacing the fixed-destination test writer. It adds configurable flit/ID widths, four destination modes (fixed, round-robin, pseudo-random, loopback), an inter-flit gap throttle and a packet-count limit with a done flag. One instance drives each node's write port in the NoC testbenches; the same backpressure rule against the router FIFO `full`/`almost_full` is kept.

---
 rtl/noc_traffic_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/noc_traffic_gen.sv
// Flit injector for one NoC router input port: four destination modes, idle-gap throttle,
// packet limit with done flag, and the router's full/almost_full backpressure rule.
module noc_traffic_gen #(
    parameter int          DATA_W  = 16,
    parameter int          ID_W    = 2,
    parameter int          LIMIT_W = 16,
    parameter int          GAP_W   = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               full,
    input  logic               almost_full,
    input  logic [ID_W-1:0]    id,
    input  logic [ID_W-1:0]    to,
    input  logic [1:0]         mode,
    input  logic               enable,
    input  logic [GAP_W-1:0]   gap,
    input  logic [LIMIT_W-1:0] limit,
    output logic [DATA_W-1:0]  dataOut,
    output logic               write,
    output logic [LIMIT_W-1:0] sent_count,
    output logic               done
);

    localparam int SEQ_W = DATA_W - 2*ID_W - 1;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_RAND  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               write_q, write_d;
    logic [LIMIT_W-1:0] sent_q, sent_d;
    logic               done_q, done_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               can_issue;
    logic [ID_W-1:0]    dest;
    logic [15:0]        lfsr_next;
    logic [LIMIT_W:0]   sent_inc;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign sent_inc  = {1'b0, sent_q} + (LIMIT_W+1)'(1);
    // A strobe in flight already consumes the slot that almost_full advertises
    assign can_issue = ~((write_q & almost_full) | (~write_q & full));

    always_comb begin
        case (mode)
            MODE_FIXED: dest = to;
            MODE_RR:    dest = rr_q;
            MODE_RAND:  dest = lfsr_q[ID_W-1:0];
            default:    dest = id;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        write_d   = 1'b0;
        sent_d    = sent_q;
        done_d    = done_q;
        seq_d     = seq_q;
        rr_d      = rr_q;
        lfsr_d    = lfsr_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_SEND;
            end
            S_SEND: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (can_issue) begin
                    write_d = 1'b1;
                    data_d  = {seq_q, id, dest, 1'b1};
                    seq_d   = seq_q + SEQ_W'(1);
                    if (sent_q != '1) sent_d = sent_q + LIMIT_W'(1);
                    if (mode == MODE_RR)   rr_d   = rr_q + ID_W'(1);
                    if (mode == MODE_RAND) lfsr_d = lfsr_next;
                    if (limit != '0 && sent_inc == {1'b0, limit}) begin
                        state_d = S_DONE;
                    end else if (gap != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q <= GAP_W'(1)) state_d = enable ? S_SEND : S_IDLE;
            end
            default: begin
                done_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            write_q   <= 1'b0;
            sent_q    <= '0;
            done_q    <= 1'b0;
            seq_q     <= '0;
            rr_q      <= '0;
            lfsr_q    <= SEED;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            write_q   <= write_d;
            sent_q    <= sent_d;
            done_q    <= done_d;
            seq_q     <= seq_d;
            rr_q      <= rr_d;
            lfsr_q    <= lfsr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign dataOut    = data_q;
    assign write      = write_q;
    assign sent_count = sent_q;
    assign done       = done_q;

endmodule
